// File: rtl/stack_pkg.sv
// Shared constants, default widths and FSM state type for the stack arbiter slice.
package stack_pkg;

    localparam int unsigned N_REQ_DEF  = 4;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned OP_W_DEF   = 3;

    localparam logic [2:0] OP_PUSH = 3'b101;
    localparam logic [2:0] OP_POP  = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] k;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = PW'((32'(ptr) + i) % N);
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/stack_op_arbiter.sv
// Round-robin arbiter sharing one stack datapath between N_REQ requesters.
// Optional feature: define STACK_ARB_LOCK_EN to add req_lock (grant hold for
// atomic multi-op sequences).
module stack_op_arbiter
    import stack_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*OP_W-1:0]    req_op,
    input  logic [N_REQ*DATA_W-1:0]  req_in,
`ifdef STACK_ARB_LOCK_EN
    input  logic [N_REQ-1:0]         req_lock,
`endif
    output logic [N_REQ-1:0]         ack,
    output logic [DATA_W-1:0]        rsp_tail,
    output logic                     rsp_empty,
    output logic                     rsp_err,
    output logic [DATA_W-1:0]        dp_in,
    output logic [OP_W-1:0]          dp_op,
    output logic                     dp_apply,
    input  logic [DATA_W-1:0]        dp_tail,
    input  logic                     dp_empty,
    input  logic                     dp_valid,
    output logic                     busy
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    g_idx;
    logic [N_REQ-1:0] g_oh;

    logic [N_REQ-1:0] pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;
    logic [PW-1:0]    ptr_next;
    logic             lock_hold;

    logic [OP_W-1:0]   op_slot [N_REQ];
    logic [DATA_W-1:0] in_slot [N_REQ];

    // Unpack the flat request buses into per-requester slots.
    for (genvar gi = 0; gi < int'(N_REQ); gi++) begin : g_unpack
        assign op_slot[gi] = req_op[gi*OP_W +: OP_W];
        assign in_slot[gi] = req_in[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign ptr_next = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + PW'(1);

`ifdef STACK_ARB_LOCK_EN
    assign lock_hold = req_lock[g_idx];
`else
    assign lock_hold = 1'b0;
`endif

    // Arbitration FSM: pick, pulse apply, capture response, acknowledge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            g_idx     <= '0;
            g_oh      <= '0;
            ack       <= '0;
            dp_apply  <= 1'b0;
            dp_op     <= '0;
            dp_in     <= '0;
            rsp_tail  <= '0;
            rsp_empty <= 1'b1;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ack      <= '0;
            dp_apply <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        g_idx    <= pick_idx;
                        g_oh     <= pick_oh;
                        dp_op    <= op_slot[pick_idx];
                        dp_in    <= in_slot[pick_idx];
                        dp_apply <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_tail  <= dp_tail;
                    rsp_empty <= dp_empty;
                    rsp_err   <= !dp_valid;
                    ack       <= g_oh;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (!lock_hold) begin
                        rr_ptr <= ptr_next;
                    end
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_op_arbiter.sv
// Self-checking bench for stack_op_arbiter with a behavioural stack datapath.
module tb_stack_op_arbiter;
    import stack_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned OW = 3;
    localparam logic [2:0] OP_ADD = 3'b110;

    typedef struct {
        logic [1:0] idx;
        logic [2:0] op;
        logic [7:0] din;
        logic [7:0] tail;
        logic       empty;
        logic       err;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    req;
    logic [N*OW-1:0] req_op;
    logic [N*DW-1:0] req_in;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rsp_tail;
    logic            rsp_empty;
    logic            rsp_err;
    logic [DW-1:0]   dp_in;
    logic [OW-1:0]   dp_op;
    logic            dp_apply;
    logic [DW-1:0]   dp_tail  = 8'h00;
    logic            dp_empty = 1'b1;
    logic            dp_valid = 1'b1;
    logic            busy;

    logic [2:0] r_op [N];
    logic [7:0] r_in [N];

    for (genvar gi = 0; gi < int'(N); gi++) begin : g_pack
        assign req_op[gi*OW +: OW] = r_op[gi];
        assign req_in[gi*DW +: DW] = r_in[gi];
    end

    always #5 clk = ~clk;

    stack_op_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW),
        .OP_W   (OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_op    (req_op),
        .req_in    (req_in),
`ifdef STACK_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .ack       (ack),
        .rsp_tail  (rsp_tail),
        .rsp_empty (rsp_empty),
        .rsp_err   (rsp_err),
        .dp_in     (dp_in),
        .dp_op     (dp_op),
        .dp_apply  (dp_apply),
        .dp_tail   (dp_tail),
        .dp_empty  (dp_empty),
        .dp_valid  (dp_valid),
        .busy      (busy)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned cyc = 0;
    int unsigned last_apply_cyc = 0;
    int unsigned n_apply = 0;
    int unsigned exp_apply = 0;
    int unsigned ack_cyc [$];
    txn_t sb [$];
    txn_t mon_t;
    logic apply_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_note(input string name);
        n_total++;
        $display("FAIL %s", name);
    endtask

    function automatic txn_t mk(input logic [1:0] i, input logic [2:0] op, input logic [7:0] din,
                                input logic [7:0] tail, input logic empty, input logic err);
        txn_t t;
        t.idx = i; t.op = op; t.din = din; t.tail = tail; t.empty = empty; t.err = err;
        return t;
    endfunction

    // Behavioural stack standing in for main: acts on apply, outputs settle next edge.
    logic [7:0] stk [16];
    logic [4:0] depth = 5'd0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dp_apply === 1'b1) begin
            logic ok;
            ok = 1'b1;
            case (dp_op)
                OP_PUSH: if (depth < 5'd16) begin stk[depth[3:0]] = dp_in; depth = depth + 5'd1; end
                         else ok = 1'b0;
                OP_POP:  if (depth > 5'd0) depth = depth - 5'd1; else ok = 1'b0;
                OP_ADD:  if (depth >= 5'd2) begin
                             stk[4'(depth - 5'd2)] = stk[4'(depth - 5'd2)] + stk[4'(depth - 5'd1)];
                             depth = depth - 5'd1;
                         end else ok = 1'b0;
                default: ok = 1'b0;
            endcase
            dp_valid <= ok;
            dp_empty <= (depth == 5'd0);
            dp_tail  <= (depth > 5'd0) ? stk[4'(depth - 5'd1)] : 8'h00;
        end
    end

    // Monitor: check forwarded op on apply, pop scoreboard on ack.
    always @(negedge clk) begin
        if (dp_apply === 1'b1) begin
            n_apply++;
            check("apply_one_cycle", 32'(apply_prev), 32'h0);
            if (sb.size() != 0) begin
                check("dp_op", 32'(dp_op), 32'(sb[0].op));
                check("dp_in", 32'(dp_in), 32'(sb[0].din));
            end
            last_apply_cyc = cyc;
        end
        if ((|ack) === 1'b1) begin
            ack_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                fail_note($sformatf("unexpected_ack ack=%b", ack));
            end else begin
                mon_t = sb.pop_front();
                check("ack_onehot", 32'(ack), 32'(4'b0001 << mon_t.idx));
                check("rsp_tail", 32'(rsp_tail), 32'(mon_t.tail));
                check("rsp_empty", 32'(rsp_empty), 32'(mon_t.empty));
                check("rsp_err", 32'(rsp_err), 32'(mon_t.err));
                check("apply_to_ack", cyc - last_apply_cyc, 32'd2);
                check("busy_in_done", 32'(busy), 32'h1);
            end
        end
        apply_prev = dp_apply;
    end

    task automatic expect_txn(input txn_t t);
        sb.push_back(t);
        exp_apply++;
    endtask

    task automatic arm(input txn_t t);
        r_op[t.idx] = t.op;
        r_in[t.idx] = t.din;
        req[t.idx]  = 1'b1;
    endtask

    // Run until every expected ack arrived; each requester drops req on its ack.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
            if ((|ack) === 1'b1) req = req & ~ack;
        end
        if (sb.size() != 0) begin
            fail_note($sformatf("drain_timeout pending=%0d", sb.size()));
            sb.delete();
        end
    endtask

    task automatic check_spacing(input string name, input int unsigned cnt);
        check({name, "_acks"}, ack_cyc.size(), cnt);
        if (ack_cyc.size() == cnt)
            for (int unsigned i = 1; i < cnt; i++)
                check({name, "_spacing"}, ack_cyc[i] - ack_cyc[i-1], 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        txn_t vec [7];
        txn_t t;
        int k;
        int n;

        vec[0] = mk(2'd0, OP_PUSH, 8'h01, 8'h01, 1'b0, 1'b0);
        vec[1] = mk(2'd1, OP_POP,  8'h00, 8'h00, 1'b1, 1'b0);
        vec[2] = mk(2'd2, OP_POP,  8'h00, 8'h00, 1'b1, 1'b1);
        vec[3] = mk(2'd0, OP_PUSH, 8'h04, 8'h04, 1'b0, 1'b0);
        vec[4] = mk(2'd2, OP_PUSH, 8'h07, 8'h07, 1'b0, 1'b0);
        vec[5] = mk(2'd1, OP_ADD,  8'h00, 8'h0B, 1'b0, 1'b0);
        vec[6] = mk(2'd3, OP_POP,  8'h00, 8'h00, 1'b1, 1'b0);

        rst = 1'b0;
        req = '0;
        req_lock = '0;
        for (int i = 0; i < int'(N); i++) begin r_op[i] = 3'b000; r_in[i] = 8'h00; end

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dp_apply", 32'(dp_apply), 32'h0);
        check("rst_dp_op", 32'(dp_op), 32'h0);
        check("rst_dp_in", 32'(dp_in), 32'h0);
        check("rst_rsp_tail", 32'(rsp_tail), 32'h0);
        check("rst_rsp_empty", 32'(rsp_empty), 32'h1);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_no_apply", n_apply, 32'd0);
        #1 rst = 1'b1;

        // Table of single requests, one at a time
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
            check("idle_busy", 32'(busy), 32'h0);
            expect_txn(vec[i]);
            arm(vec[i]);
            drain(20);
        end

        // Four-way contention from rr_ptr=0
        @(negedge clk); #1;
        ack_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            t = mk(2'(i), OP_PUSH, 8'(16 + i), 8'(16 + i), 1'b0, 1'b0);
            expect_txn(t);
            arm(t);
        end
        drain(40);
        check_spacing("contention", 4);

        // req3 and req0 together: req0 first
        @(negedge clk); #1;
        t = mk(2'd0, OP_POP, 8'h00, 8'h12, 1'b0, 1'b0); expect_txn(t); arm(t);
        t = mk(2'd3, OP_POP, 8'h00, 8'h11, 1'b0, 1'b0); expect_txn(t); arm(t);
        drain(40);

        // Move pointer to 2, then req1 and req3: req3 first
        @(negedge clk); #1;
        t = mk(2'd1, OP_PUSH, 8'h20, 8'h20, 1'b0, 1'b0); expect_txn(t); arm(t);
        drain(20);
        @(negedge clk); #1;
        t = mk(2'd3, OP_POP,  8'h00, 8'h11, 1'b0, 1'b0); expect_txn(t); arm(t);
        t = mk(2'd1, OP_PUSH, 8'h30, 8'h30, 1'b0, 1'b0); expect_txn(t); arm(t);
        drain(40);

        // Single requester held high: back-to-back every 4 cycles
        @(negedge clk); #1;
        ack_cyc.delete();
        t = mk(2'd2, OP_PUSH, 8'h40, 8'h40, 1'b0, 1'b0);
        expect_txn(t); expect_txn(t); arm(t);
        k = 0; n = 0;
        while (k < 2 && n < 30) begin
            @(negedge clk); #1;
            n++;
            if (ack[2] === 1'b1) begin k++; if (k == 2) req[2] = 1'b0; end
        end
        if (k < 2) fail_note("b2b_timeout");
        check_spacing("b2b", 2);

        // Reset landing in CAPTURE: no ack, back to IDLE, pointer cleared
        @(negedge clk); #1;
        t = mk(2'd3, OP_PUSH, 8'h50, 8'h50, 1'b0, 1'b0);
        arm(t);
        exp_apply++;
        @(negedge clk); #1;
        check("midop_apply", 32'(dp_apply), 32'h1);
        @(negedge clk); #1;
        check("midop_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        req = '0;
        @(negedge clk); #1;
        check("midop_rst_busy", 32'(busy), 32'h0);
        check("midop_rst_ack", 32'(ack), 32'h0);
        check("midop_rst_apply", 32'(dp_apply), 32'h0);
        check("midop_rst_empty", 32'(rsp_empty), 32'h1);
        check("midop_rst_tail", 32'(rsp_tail), 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("midop_no_ack", 32'(ack), 32'h0);
        end
        // Pointer is 0 again: req0 beats req3
        t = mk(2'd0, OP_POP, 8'h00, 8'h40, 1'b0, 1'b0); expect_txn(t); arm(t);
        t = mk(2'd3, OP_POP, 8'h00, 8'h40, 1'b0, 1'b0); expect_txn(t); arm(t);
        drain(40);

`ifdef STACK_ARB_LOCK_EN
        // Locked requester 1 runs push, push, add before pending requester 2
        @(negedge clk); #1;
        expect_txn(mk(2'd1, OP_PUSH, 8'h04, 8'h04, 1'b0, 1'b0));
        expect_txn(mk(2'd1, OP_PUSH, 8'h06, 8'h06, 1'b0, 1'b0));
        expect_txn(mk(2'd1, OP_ADD,  8'h06, 8'h0A, 1'b0, 1'b0));
        expect_txn(mk(2'd2, OP_PUSH, 8'h77, 8'h77, 1'b0, 1'b0));
        req_lock[1] = 1'b1;
        arm(mk(2'd1, OP_PUSH, 8'h04, 8'h04, 1'b0, 1'b0));
        arm(mk(2'd2, OP_PUSH, 8'h77, 8'h77, 1'b0, 1'b0));
        k = 0; n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk); #1;
            n++;
            if (ack[1] === 1'b1) begin
                k++;
                if (k == 1) begin r_op[1] = OP_PUSH; r_in[1] = 8'h06; end
                if (k == 2) begin r_op[1] = OP_ADD; end
                if (k == 3) begin req[1] = 1'b0; req_lock[1] = 1'b0; end
            end
            if (ack[2] === 1'b1) req[2] = 1'b0;
        end
        if (sb.size() != 0) begin fail_note("lock_timeout"); sb.delete(); end
`endif

        repeat (3) @(negedge clk);
        check("apply_count", n_apply, exp_apply);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stack_op_arbiter.md
# stack_op_arbiter

Shares the single stack datapath (`main`: `in`/`op`/`apply` in; `tail`/`empty`/`valid` out) between `N_REQ` independent requesters. Each requester posts one operation with a req/ack handshake. The arbiter grants round-robin, drives a one-cycle `apply` pulse into the datapath, captures the datapath's response and returns it to the granted requester. It sits between the command sources and `main`, and is the only block permitted to drive `main`'s `apply`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: operand/tail width.
- `OP_W`, default 3: opcode width.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-low reset.
- `req`  in  N_REQ: per-requester request level.
- `req_op`  in  N_REQ*OP_W: opcodes, requester i at bits [i*OP_W +: OP_W].
- `req_in`  in  N_REQ*DATA_W: operands, same packing.
- `req_lock`  in  N_REQ: hold-grant request; present only with `STACK_ARB_LOCK_EN`.
- `ack`  out  N_REQ: one-hot, one-cycle completion strobe.
- `rsp_tail`  out  DATA_W: datapath `tail` captured for the completed op.
- `rsp_empty`  out  1: datapath `empty` captured.
- `rsp_err`  out  1: inverse of the captured datapath `valid`.
- `dp_in`  out  DATA_W: to `main.in`.
- `dp_op`  out  OP_W: to `main.op`.
- `dp_apply`  out  1: to `main.apply`.
- `dp_tail`  in  DATA_W: from `main.tail`.
- `dp_empty`  in  1: from `main.empty`.
- `dp_valid`  in  1: from `main.valid`.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - If any `req` bit is set, pick winner g round-robin, starting the search at pointer `rr_ptr`.
  - Latch g, `req_op[g]` and `req_in[g]`, then go to ISSUE.
  - If no `req` bit is set, stay in IDLE.
- ISSUE: `dp_apply`=1; `dp_op`/`dp_in` = latched values. Go to CAPTURE.
- CAPTURE: register `dp_tail`, `dp_empty` and `!dp_valid` into `rsp_*`. Go to DONE.
- DONE: `ack[g]`=1; set `rr_ptr` = (g+1) mod N_REQ. Go to IDLE.
- Opcodes are opaque to the arbiter and forwarded unchanged. `rsp_err`=1 means the datapath rejected the op (for example a pop on an empty stack). The arbiter takes no recovery action.
- `dp_op`/`dp_in` hold their last values outside ISSUE. `dp_apply` is 0 outside ISSUE.
- `req` is sampled only in IDLE. A request withdrawn before it is granted is dropped silently. Once granted, the op completes regardless of `req`.
- Requesters keep `req`, op and operand stable until `ack`. They deassert `req` in the cycle after `ack`; a `req` still high in the next IDLE is a new request.
- `rsp_*` remain valid until the next CAPTURE.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `ack`=0, `dp_apply`=0, `dp_op`=0, `dp_in`=0, `rsp_tail`=0, `rsp_empty`=1, `rsp_err`=0, `busy`=0.
- Latency: request seen in IDLE at cycle T → `dp_apply` at T+1 → capture at T+2 → `ack` at T+3.
- Throughput: one op per 4 cycles under continuous load.
- Datapath contract: `main` acts on `apply` at the edge ending ISSUE, and its outputs are settled by the next edge.
- Simultaneous requests: the lowest index at or after `rr_ptr`, wrapping, wins.
- Single requester: served back-to-back, every 4 cycles.
- Pointer wrap: after g = N_REQ-1, `rr_ptr` returns to 0.
- Reset mid-operation (`rst`=0 in any state): next edge forces IDLE. The outstanding op gets no `ack`. If the reset lands in ISSUE, the datapath has already applied the op. The arbiter does not reset `main`.

## Configuration
- `STACK_ARB_LOCK_EN` defined:
  - The `req_lock` port exists.
  - In DONE, if `req_lock[g]` is high, `rr_ptr` is left unchanged, so g wins the next IDLE if it requests. Use this for atomic multi-op sequences such as push, push, add.
  - When `req_lock[g]` drops, normal rotation resumes.
- `STACK_ARB_LOCK_EN` undefined: no `req_lock` port; pure round-robin.

## Structure
- Package `stack_pkg`:
  - Constants `OP_PUSH`=3'b101 and `OP_POP`=3'b000.
  - FSM state typedef.
  - Default widths.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs: `req` vector and `rr_ptr`. Outputs: one-hot grant and its index, plus `any`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles → all outputs at their reset values, `dp_apply` never pulses.
- Single op: req0 pushes 0x01 → exactly one `dp_apply` at T+1 with `dp_op`=101, `dp_in`=0x01; `ack[0]` at T+3 with `rsp_tail`=0x01, `rsp_empty`=0.
- Contention: req0..3 push 0x10/0x11/0x12/0x13 in the same cycle → grants in order 0,1,2,3, each `ack` 4 cycles apart. Then req3 and req0 together → req0 wins.
- Error path: pop (000) on an empty datapath → `ack`, `rsp_err`=1, `rsp_empty`=1; the next push 0x04 gives `rsp_err`=0.
- Reset mid-op: `rst`=0 during CAPTURE → no `ack`, state IDLE, `rr_ptr`=0.
- Lock (macro on): req1 with lock pushes 0x04 then 0x06 then op 110 while req2 is pending → req1 acked three times consecutively, then req2 is served.
